// File: rtl/frame_sched_pkg.sv
// Shared display-pipeline definitions: scheduler state encoding, pixel
// field widths and screen geometry used by the VGA-side blocks.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int C_W      = 3;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame counter: 0..FRAME_CYCLES-1, wrapping, with a tick
// in the cycle the count sits at its last value.
module frame_tick_gen #(
  parameter int FRAME_CYCLES = 833333
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // next count with wrap at the frame boundary
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == LAST) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame arbiter for the VGA pixel-write port: runs each pixel engine once
// per frame tick in index order and muxes the granted engine onto the adapter.
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int NUM_CLIENTS  = 3,
  parameter int FRAME_CYCLES = 833333,
  parameter int TIMEOUT      = 32768
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CLIENTS-1:0]       done_in,
  input  logic [NUM_CLIENTS-1:0]       plot_in,
  input  logic [X_W*NUM_CLIENTS-1:0]   x_in,
  input  logic [Y_W*NUM_CLIENTS-1:0]   y_in,
  input  logic [C_W*NUM_CLIENTS-1:0]   c_in,
  input  logic                         clear_err,
  output logic [NUM_CLIENTS-1:0]       en_out,
  output logic [X_W-1:0]               vga_x,
  output logic [Y_W-1:0]               vga_y,
  output logic [C_W-1:0]               vga_colour,
  output logic                         vga_plot,
  output logic                         frame_start,
  output logic                         busy,
  output logic                         overrun,
  output logic [7:0]                   missed_frames,
  output logic [NUM_CLIENTS-1:0]       timeout_err
);

  localparam int KW = $clog2(NUM_CLIENTS);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [KW-1:0] LAST_K = KW'(NUM_CLIENTS - 1);
  localparam logic [TW-1:0] LAST_T = TW'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [NUM_CLIENTS-1:0] en_q, en_d;
  logic [NUM_CLIENTS-1:0] timeout_set;
  logic [NUM_CLIENTS-1:0] timeout_err_q;
  logic                   busy_q, frame_start_q, overrun_q, vga_plot_q;
  logic [7:0]             missed_q;
  logic [X_W-1:0]         vga_x_q;
  logic [Y_W-1:0]         vga_y_q;
  logic [C_W-1:0]         vga_c_q;
  logic                   tick;
  logic                   overrun_set;

  frame_tick_gen #(.FRAME_CYCLES(FRAME_CYCLES)) u_tick (
    .clk    (clk),
    .rst_n  (reset),
    .tick_o (tick)
  );

  // a tick that finds the scheduler mid-frame is dropped, not queued
  assign overrun_set = tick && (state_q != IDLE);

  // next-state, client index, grant timer and timeout detection
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    timer_d     = timer_q;
    timeout_set = {NUM_CLIENTS{1'b0}};
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = GRANT;
          k_d     = {KW{1'b0}};
          timer_d = {TW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (done_in[k_q]) begin
          state_d = RELEASE;
        end else if (timer_q == LAST_T) begin
          state_d          = RELEASE;
          timeout_set[k_q] = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RELEASE: begin
        timer_d = {TW{1'b0}};
        if (k_q == LAST_K) begin
          state_d = IDLE;
        end else begin
          state_d = GRANT;
          k_d     = k_q + KW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = {KW{1'b0}};
        timer_d = {TW{1'b0}};
      end
    endcase
  end

  // one-hot enable derived from the upcoming state so it is registered
  always_comb begin
    en_d = {NUM_CLIENTS{1'b0}};
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      en_d[i] = (state_d == GRANT) && (k_d == KW'(i));
    end
  end

  // FSM state and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      k_q           <= {KW{1'b0}};
      timer_q       <= {TW{1'b0}};
      en_q          <= {NUM_CLIENTS{1'b0}};
      busy_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      timer_q       <= timer_d;
      en_q          <= en_d;
      busy_q        <= (state_d != IDLE);
      frame_start_q <= (state_q == IDLE) && tick;
    end
  end

  // adapter mux: fields hold outside GRANT, the strobe does not
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_x_q    <= {X_W{1'b0}};
      vga_y_q    <= {Y_W{1'b0}};
      vga_c_q    <= {C_W{1'b0}};
      vga_plot_q <= 1'b0;
    end else if (state_q == GRANT) begin
      vga_x_q    <= x_in[int'(k_q)*X_W +: X_W];
      vga_y_q    <= y_in[int'(k_q)*Y_W +: Y_W];
      vga_c_q    <= c_in[int'(k_q)*C_W +: C_W];
      vga_plot_q <= plot_in[k_q] & ~done_in[k_q];
    end else begin
      vga_plot_q <= 1'b0;
    end
  end

  // sticky error flags; a same-cycle set beats clear_err
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q     <= 1'b0;
      missed_q      <= 8'd0;
      timeout_err_q <= {NUM_CLIENTS{1'b0}};
    end else begin
      timeout_err_q <= (clear_err ? {NUM_CLIENTS{1'b0}} : timeout_err_q) | timeout_set;
      if (overrun_set) begin
        overrun_q <= 1'b1;
        if (missed_q != 8'hFF) begin
          missed_q <= missed_q + 8'd1;
        end else begin
          missed_q <= missed_q;
        end
      end else if (clear_err) begin
        overrun_q <= 1'b0;
        missed_q  <= 8'd0;
      end else begin
        overrun_q <= overrun_q;
        missed_q  <= missed_q;
      end
    end
  end

  assign en_out        = en_q;
  assign busy          = busy_q;
  assign frame_start   = frame_start_q;
  assign vga_x         = vga_x_q;
  assign vga_y         = vga_y_q;
  assign vga_colour    = vga_c_q;
  assign vga_plot      = vga_plot_q;
  assign overrun       = overrun_q;
  assign missed_frames = missed_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: main instance FRAME_CYCLES=200/TIMEOUT=50,
// second instance with a long timeout so a client can hold the grant across a tick.
module tb_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  done_in, plot_in, force_done;
  logic [23:0] x_in;
  logic [20:0] y_in;
  logic [8:0]  c_in;
  logic        clr;
  logic [2:0]  en_out, timeout_err;
  logic [7:0]  vga_x, missed_frames;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, frame_start, busy, overrun;

  logic [2:0]  o_done, o_req, o_en, o_terr;
  logic        o_clr, o_plot, o_fs, o_busy, o_ovr;
  logic [7:0]  o_x, o_missed;
  logic [6:0]  o_y;
  logic [2:0]  o_c;

  int delay [3];
  int ecnt  [3];
  int cyc;
  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign plot_in = 3'b111;
  assign x_in    = {8'd99, 8'd37, 8'd11};
  assign y_in    = {7'd77, 7'd22, 7'd3};
  assign c_in    = {3'd6, 3'd5, 3'd2};

  // client models: done raised delay[k] cycles after enable, held while enabled
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) ecnt[k] <= en_out[k] ? ecnt[k] + 1 : 0;
  end

  always_comb begin
    done_in = force_done;
    for (int k = 0; k < 3; k++) begin
      if (en_out[k] && (ecnt[k] >= delay[k])) done_in[k] = 1'b1;
    end
  end

  assign o_done = o_en & o_req;

  frame_scheduler #(.NUM_CLIENTS(3), .FRAME_CYCLES(200), .TIMEOUT(50)) u_dut (
    .clk(clk), .reset(reset), .done_in(done_in), .plot_in(plot_in),
    .x_in(x_in), .y_in(y_in), .c_in(c_in), .clear_err(clr),
    .en_out(en_out), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .frame_start(frame_start), .busy(busy),
    .overrun(overrun), .missed_frames(missed_frames), .timeout_err(timeout_err));

  frame_scheduler #(.NUM_CLIENTS(3), .FRAME_CYCLES(200), .TIMEOUT(512)) u_ovr (
    .clk(clk), .reset(reset), .done_in(o_done), .plot_in(plot_in),
    .x_in(x_in), .y_in(y_in), .c_in(c_in), .clear_err(o_clr),
    .en_out(o_en), .vga_x(o_x), .vga_y(o_y), .vga_colour(o_c),
    .vga_plot(o_plot), .frame_start(o_fs), .busy(o_busy),
    .overrun(o_ovr), .missed_frames(o_missed), .timeout_err(o_terr));

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int d0, input int d1, input int d2);
    reset = 1'b0; clr = 1'b0; o_clr = 1'b0; force_done = 3'b000; o_req = 3'b000;
    delay[0] = d0; delay[1] = d1; delay[2] = d2;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset(10, 5, 5);
    tests_run++;
    if ({en_out, vga_x, vga_y, vga_colour, vga_plot, frame_start, busy} !== 25'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs en=%b x=%0d y=%0d c=%0d plot=%b fs=%b busy=%b expected all 0",
               en_out, vga_x, vga_y, vga_colour, vga_plot, frame_start, busy);
    end
    tests_run++;
    if ({overrun, missed_frames, timeout_err} !== 12'd0) begin
      tests_failed++;
      $display("FAIL reset_errors ovr=%b missed=%0d terr=%b expected 0", overrun, missed_frames, timeout_err);
    end
  endtask

  task automatic test_normal_and_mux();
    logic [2:0] exp_en;
    do_reset(10, 5, 5);
    while (cyc < 230) begin
      step();
      exp_en = (cyc >= 200 && cyc <= 210) ? 3'b001 :
               (cyc >= 212 && cyc <= 217) ? 3'b010 :
               (cyc >= 219 && cyc <= 224) ? 3'b100 : 3'b000;
      tests_run++;
      if (en_out !== exp_en) begin
        tests_failed++;
        $display("FAIL normal_en cyc=%0d got %b expected %b", cyc, en_out, exp_en);
      end
      tests_run++;
      if (busy !== (cyc >= 200 && cyc <= 225)) begin
        tests_failed++;
        $display("FAIL normal_busy cyc=%0d got %b", cyc, busy);
      end
      tests_run++;
      if (frame_start !== (cyc == 200)) begin
        tests_failed++;
        $display("FAIL normal_frame_start cyc=%0d got %b", cyc, frame_start);
      end
      if (cyc >= 213 && cyc <= 217) begin
        tests_run++;
        if ({vga_x, vga_y, vga_colour, vga_plot} !== {8'd37, 7'd22, 3'd5, 1'b1}) begin
          tests_failed++;
          $display("FAIL mux_client1 cyc=%0d got x=%0d y=%0d c=%0d plot=%b expected 37 22 5 1",
                   cyc, vga_x, vga_y, vga_colour, vga_plot);
        end
      end
      if (cyc == 212) begin
        tests_run++;
        if ({vga_x, vga_plot} !== {8'd11, 1'b0}) begin
          tests_failed++;
          $display("FAIL mux_hold cyc=212 got x=%0d plot=%b expected 11 0", vga_x, vga_plot);
        end
      end
      if (cyc == 221) begin
        tests_run++;
        if ({vga_x, vga_y, vga_colour} !== {8'd99, 7'd77, 3'd6}) begin
          tests_failed++;
          $display("FAIL mux_client2 got x=%0d y=%0d c=%0d expected 99 77 6", vga_x, vga_y, vga_colour);
        end
      end
    end
    tests_run++;
    if (timeout_err !== 3'b000) begin
      tests_failed++;
      $display("FAIL normal_no_timeout got %b expected 000", timeout_err);
    end
  endtask

  task automatic test_timeout();
    int high_cnt = 0;
    int first_hi = -1;
    do_reset(10, 5, 1000);
    while (cyc < 275) begin
      step();
      if (en_out[2]) begin
        high_cnt++;
        if (first_hi < 0) first_hi = cyc;
      end
      if (cyc == 268 || cyc == 269) begin
        tests_run++;
        if (timeout_err !== ((cyc == 269) ? 3'b100 : 3'b000)) begin
          tests_failed++;
          $display("FAIL timeout_flag cyc=%0d got %b", cyc, timeout_err);
        end
      end
      if (cyc == 269 || cyc == 270) begin
        tests_run++;
        if (busy !== (cyc == 269)) begin
          tests_failed++;
          $display("FAIL timeout_busy cyc=%0d got %b", cyc, busy);
        end
      end
    end
    tests_run++;
    if (high_cnt !== 50 || first_hi !== 219) begin
      tests_failed++;
      $display("FAIL timeout_len got %0d cycles from %0d expected 50 from 219", high_cnt, first_hi);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    tests_run++;
    if (timeout_err !== 3'b000) begin
      tests_failed++;
      $display("FAIL timeout_clear got %b expected 000", timeout_err);
    end
  endtask

  task automatic test_overrun();
    int fs_cnt = 0;
    do_reset(10, 5, 5);
    while (cyc < 410) begin
      step();
      if (cyc > 200 && o_fs) fs_cnt++;
      o_clr = (cyc == 399);
      if (cyc == 399) begin
        tests_run++;
        if ({o_ovr, o_missed} !== 9'd0) begin
          tests_failed++;
          $display("FAIL overrun_before got ovr=%b missed=%0d expected 0 0", o_ovr, o_missed);
        end
      end
      if (cyc == 400) begin
        tests_run++;
        if ({o_ovr, o_missed} !== {1'b1, 8'd1}) begin
          tests_failed++;
          $display("FAIL overrun_set got ovr=%b missed=%0d expected 1 1", o_ovr, o_missed);
        end
      end
    end
    tests_run++;
    if (fs_cnt !== 0) begin
      tests_failed++;
      $display("FAIL overrun_frame_start got %0d extra pulses expected 0", fs_cnt);
    end
    o_req = 3'b111;
    while (cyc < 416) step();
    tests_run++;
    if ({o_busy, o_ovr} !== 2'b01) begin
      tests_failed++;
      $display("FAIL overrun_drain got busy=%b ovr=%b expected 0 1", o_busy, o_ovr);
    end
    o_clr = 1'b1;
    step();
    o_clr = 1'b0;
    tests_run++;
    if ({o_ovr, o_missed, o_terr} !== 12'd0) begin
      tests_failed++;
      $display("FAIL overrun_clear got ovr=%b missed=%0d terr=%b expected 0", o_ovr, o_missed, o_terr);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset(10, 5, 5);
    while (cyc < 214) step();
    tests_run++;
    if ({en_out, vga_plot, busy} !== {3'b010, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL midreset_pre got en=%b plot=%b busy=%b expected 010 1 1", en_out, vga_plot, busy);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if ({en_out, vga_plot, busy, vga_x} !== 13'd0) begin
      tests_failed++;
      $display("FAIL midreset_async got en=%b plot=%b busy=%b x=%0d expected 0", en_out, vga_plot, busy, vga_x);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    while (cyc < 202) begin
      step();
      tests_run++;
      if (frame_start !== (cyc == 200)) begin
        tests_failed++;
        $display("FAIL midreset_restart cyc=%0d frame_start=%b", cyc, frame_start);
      end
    end
  endtask

  task automatic test_done_hazard();
    logic [2:0] exp_en;
    do_reset(10, 5, 5);
    force_done = 3'b010;
    while (cyc < 225) begin
      step();
      exp_en = (cyc >= 200 && cyc <= 210) ? 3'b001 :
               (cyc == 212)               ? 3'b010 :
               (cyc >= 214 && cyc <= 219) ? 3'b100 : 3'b000;
      tests_run++;
      if (en_out !== exp_en) begin
        tests_failed++;
        $display("FAIL hazard_en cyc=%0d got %b expected %b", cyc, en_out, exp_en);
      end
    end
    force_done = 3'b000;
    tests_run++;
    if ({busy, timeout_err} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL hazard_end got busy=%b terr=%b expected 0 000", busy, timeout_err);
    end
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; o_clr = 1'b0; force_done = 3'b000; o_req = 3'b000;
    delay[0] = 10; delay[1] = 5; delay[2] = 5;
    cyc = 0;
    test_reset();
    test_normal_and_mux();
    test_timeout();
    test_overrun();
    test_reset_mid_frame();
    test_done_hazard();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
